// File: rtl/rr_arbiter4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4_pkg
// Purpose  : Shared definitions for the 4-way round-robin arbiter. These are
//            the FSM state encoding, the requester count and index width, and
//            the one-hot to 2-bit index encoder used on the grant path.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rr_arbiter4_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   // 4x2 encoder: assumes a one-hot or all-zero input, so an idle grant maps to 0
   function automatic logic [IDX_W-1:0] enc4(input logic [N_REQ-1:0] onehot);
      enc4 = {onehot[3] | onehot[2], onehot[3] | onehot[1]};
   endfunction

endpackage : rr_arbiter4_pkg
`default_nettype wire

// File: rtl/rr_arbiter4_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick4
// Purpose  : Combinational round-robin winner selection. The request vector
//            is rotated so that ptr becomes position 0. A fixed-priority
//            encoder then picks the lowest set position, and the winner is
//            rotated back to the original client numbering.
// Ports    : req        [3:0] in  - request vector
//            ptr        [1:0] in  - highest-priority client
//            win_onehot [3:0] out - one-hot winner (0 when no request)
//            win_idx    [1:0] out - winner index (don't-care when any=0)
//            any              out - at least one request present
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick4
   import rr_arbiter4_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N_REQ-1:0] win_onehot,
   output logic [IDX_W-1:0] win_idx,
   output logic             any
);

   logic [N_REQ-1:0] w_rot;
   logic [IDX_W-1:0] w_rot_idx;

   always_comb begin
      // Rotated position i holds client (ptr + i) mod 4; the 2-bit add wraps naturally
      for (int i = 0; i < N_REQ; i++) begin
         w_rot[i] = req[IDX_W'(i) + ptr];
      end
   end

   always_comb begin
      // Descending scan so that the lowest rotated position (nearest ptr) wins
      w_rot_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_rot_idx = IDX_W'(i);
         end
      end
   end

   assign any        = |w_rot;
   assign win_idx    = w_rot_idx + ptr;
   assign win_onehot = any ? (N_REQ'(1) << win_idx) : '0;

endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter4
// Purpose  : Round-robin arbiter with four requesters and registered one-hot
//            grant. An owner keeps its grant until it drops its request, or
//            until MAX_HOLD consecutive cycles have passed. At that point the
//            grant is handed off and preempt pulses for one cycle.
// Params   : MAX_HOLD - max consecutive grant cycles per owner, 0 = unlimited
//            CNT_W    - hold counter width, 2**CNT_W >= MAX_HOLD
// Ports    : clk               in  - clock, all state on posedge
//            rst_n             in  - asynchronous active-low reset
//            req         [3:0] in  - per-client request, held until done
//            grant       [3:0] out - registered one-hot grant
//            grant_idx   [1:0] out - registered owner index, 0 when idle
//            grant_valid       out - registered |grant
//            preempt           out - one-cycle pulse after a hold timeout
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter4
   import rr_arbiter4_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             preempt
);

   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam bit               C_LIMITED   = (MAX_HOLD != 0);

   arb_state_e       r_state,       w_state_nx;
   logic [IDX_W-1:0] r_ptr,         w_ptr_nx;
   logic [CNT_W-1:0] r_hold_cnt,    w_hold_cnt_nx;
   logic [N_REQ-1:0] r_grant,       w_grant_nx;
   logic [IDX_W-1:0] r_grant_idx;
   logic             r_grant_valid;
   logic             r_preempt,     w_preempt_nx;

   logic             w_owner_req;
   logic             w_timeout;
   logic             w_handoff;
   logic [IDX_W-1:0] w_pick_ptr;
   logic [N_REQ-1:0] w_win_onehot;
   logic [IDX_W-1:0] w_win_idx;
   logic             w_any;

   // Only the owner's request line matters while a grant is held. Other
   // clients reach the picker, but its result is used only on a hand-off edge.
   assign w_owner_req = req[r_grant_idx];
   assign w_timeout   = C_LIMITED && (r_hold_cnt == C_HOLD_LAST) && w_owner_req;
   assign w_handoff   = (r_state == ST_GRANT) && (!w_owner_req || w_timeout);

   // On a hand-off the search starts just after the outgoing owner, so the
   // next winner is chosen on the same edge and no idle cycle is inserted.
   assign w_pick_ptr  = w_handoff ? (r_grant_idx + 2'd1) : r_ptr;

   rr_pick4 u_pick (
      .req        (req),
      .ptr        (w_pick_ptr),
      .win_onehot (w_win_onehot),
      .win_idx    (w_win_idx),
      .any        (w_any)
   );

   always_comb begin
      w_state_nx    = r_state;
      w_ptr_nx      = r_ptr;
      w_hold_cnt_nx = r_hold_cnt;
      w_grant_nx    = r_grant;
      w_preempt_nx  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nx    = ST_GRANT;
               w_grant_nx    = w_win_onehot;
               w_hold_cnt_nx = '0;
            end
         end

         ST_GRANT: begin
            if (w_handoff) begin
               w_ptr_nx      = w_pick_ptr;
               w_preempt_nx  = w_timeout;
               w_hold_cnt_nx = '0;
               if (w_any) begin
                  w_grant_nx = w_win_onehot;
               end else begin
                  w_state_nx = ST_IDLE;
                  w_grant_nx = '0;
               end
            end else if (r_hold_cnt != '1) begin
               // Saturates so that an unlimited hold never wraps to a false timeout
               w_hold_cnt_nx = r_hold_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_grant_nx = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_ptr         <= '0;
         r_hold_cnt    <= '0;
         r_grant       <= '0;
         r_grant_idx   <= '0;
         r_grant_valid <= 1'b0;
         r_preempt     <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_ptr         <= w_ptr_nx;
         r_hold_cnt    <= w_hold_cnt_nx;
         r_grant       <= w_grant_nx;
         r_grant_idx   <= enc4(w_grant_nx);
         r_grant_valid <= |w_grant_nx;
         r_preempt     <= w_preempt_nx;
      end
   end

   assign grant       = r_grant;
   assign grant_idx   = r_grant_idx;
   assign grant_valid = r_grant_valid;
   assign preempt     = r_preempt;

endmodule : rr_arbiter4
`default_nettype wire

// File: tb/tb_rr_arbiter4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter4
// Purpose  : Self-checking bench for rr_arbiter4. A behavioural model predicts
//            the outputs after every clock edge and queues them. A monitor
//            pops each prediction and compares it with the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter4;

   localparam int MAX_HOLD = 8;
   localparam int CNT_W    = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [3:0] grant;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       preempt;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp_q[$];

   rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .preempt     (preempt)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit m_busy  = 0;
   int m_owner = 0;
   int m_ptr   = 0;
   int m_held  = 0;   // cycles the current owner has already been granted

   function automatic int first_in_order(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      bit pre;
      int w;
      pre = 0;
      if (!rst_n) begin
         m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0;
      end else if (!m_busy) begin
         w = first_in_order(req, m_ptr);
         if (w >= 0) begin
            m_busy = 1; m_owner = w; m_held = 1;
         end
      end else begin
         bit give_up;
         give_up = (req[m_owner] == 1'b0);
         pre = (MAX_HOLD != 0) && req[m_owner] && (m_held >= MAX_HOLD);
         if (give_up || pre) begin
            m_ptr = (m_owner + 1) % 4;
            w = first_in_order(req, m_ptr);
            if (w >= 0) begin
               m_owner = w; m_held = 1;
            end else begin
               m_busy = 0; m_owner = 0; m_held = 0;
            end
         end else begin
            m_held = m_held + 1;
         end
      end
      exp_q.push_back({(m_busy ? (4'b0001 << m_owner) : 4'b0000),
                       (m_busy ? m_owner[1:0] : 2'd0),
                       m_busy, pre});
   end

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      logic [7:0] exp_v;
      logic [7:0] act_v;
      #1;
      act_v = {grant, grant_idx, grant_valid, preempt};
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty t=%0t actual=%b required=an entry", $time, act_v);
      end else begin
         exp_v = exp_q.pop_front();
         if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL cycle_check t=%0t req=%b actual grant=%b idx=%0d valid=%b preempt=%b required grant=%b idx=%0d valid=%b preempt=%b",
                     $time, req, act_v[7:4], act_v[3:2], act_v[1], act_v[0],
                     exp_v[7:4], exp_v[3:2], exp_v[1], exp_v[0]);
         end
      end
      n_cmp++;
      if ($countones(grant) > 1) begin
         n_bad++;
         $display("FAIL onehot t=%0t actual=%b required=at most one bit", $time, grant);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int gc[4];
      // 1: reset, then idle
      cycles(2);
      rst_n = 1'b1;
      req   = 4'b0000;
      cycles(5);

      // 2: single requester
      req = 4'b0100;
      cycles(3);
      req = 4'b0000;
      cycles(3);

      // 3: all requesting, each owner releases after two granted cycles
      for (int i = 0; i < 4; i++) gc[i] = 0;
      for (int c = 0; c < 16; c++) begin
         logic [3:0] r;
         r = 4'b1111;
         for (int i = 0; i < 4; i++) begin
            gc[i] = grant[i] ? gc[i] + 1 : 0;
            if (gc[i] >= 2) begin
               r[i]  = 1'b0;
               gc[i] = 0;
            end
         end
         req = r;
         cycles(1);
      end
      req = 4'b0000;
      cycles(3);

      // 4: two clients held continuously, forced hand-off by timeout
      req = 4'b0011;
      cycles(40);
      req = 4'b0000;
      cycles(2);

      // 5: sole requester re-granted after each timeout
      req = 4'b0100;
      cycles(20);
      req = 4'b0000;
      cycles(2);

      // random traffic: requests flip occasionally so both releases and timeouts occur
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) req[$urandom_range(0, 3)] ^= 1'b1;
         if ($urandom_range(0, 40) == 0) req = 4'($urandom_range(0, 15));
         cycles(1);
      end

      // 6: asynchronous reset mid-grant, between clock edges
      req = 4'b0010;
      cycles(3);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({grant, grant_idx, grant_valid, preempt} !== 8'b0) begin
         n_bad++;
         $display("FAIL async_reset t=%0t actual grant=%b idx=%0d valid=%b preempt=%b required all zero",
                  $time, grant, grant_idx, grant_valid, preempt);
      end
      @(negedge clk);
      cycles(1);
      rst_n = 1'b1;
      // pointer back at 0: client 0 wins over client 3
      req = 4'b1001;
      cycles(3);
      req = 4'b1000;
      cycles(4);
      req = 4'b0000;
      cycles(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Safety bound against a stuck simulation
   initial begin
      #200000;
      $display("FAIL timeout t=%0t actual=running required=finished", $time);
      $fatal(1, "bench timeout");
   end

endmodule : tb_rr_arbiter4
`default_nettype wire
